// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared instruction types and widths for the fetch path
package cpu_pkg;

  localparam int INSTR_W = 22;
  localparam int PC_W    = 4;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    LOAD = 2'd2
  } opcode_t;

  typedef struct packed {
    opcode_t    opcode;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [7:0] imm;
  } instr_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue of {instruction, pc} entries with flush
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 26,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Flush wins over a same-cycle push or pop; the caller guarantees no push when full.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - credit-limited instruction prefetch with redirect flush
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = INSTR_W + PC_W;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            discard_q, discard_d;

  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;
  logic [CW:0]     used_now, used_next;
  logic            req_fire, push, pop;

  // Credit counts buffered entries plus the one outstanding request, so a response always has room.
  always_comb begin
    used_now       = (CW + 1)'(fifo_count) + (CW + 1)'(inflight_q);
    imem_req_valid = rst_n && (state_q == FETCH) && (used_now < DEPTH_C) && !redirect_valid;
    req_fire       = imem_req_valid && imem_req_ready;
    push           = imem_rsp_valid && inflight_q && !discard_q && !redirect_valid;
    pop            = out_valid && out_ready;

    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    state_d    = state_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_W'(1);
      req_pc_d   = fetch_pc_q;
    end
    if (req_fire)            inflight_d = 1'b1;
    else if (imem_rsp_valid) inflight_d = 1'b0;

    // A response still owed to a flushed request must not land in the new stream.
    if (imem_rsp_valid) discard_d = 1'b0;
    if (redirect_valid && inflight_q && !imem_rsp_valid) discard_d = 1'b1;

    if (redirect_valid) begin
      used_next = (CW + 1)'(inflight_d);
    end else begin
      used_next = (CW + 1)'(fifo_count) + (CW + 1)'(push) - (CW + 1)'(pop)
                + (CW + 1)'(inflight_d);
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      state_d    = REDIR;
    end else if (state_q == REDIR) begin
      state_d = FETCH;
    end else begin
      state_d = (used_next == DEPTH_C) ? HOLD : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rsp_data, req_pc_q}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign imem_req_addr = fetch_pc_q;
  assign out_valid     = (fifo_count != '0);
  assign out_instr     = fifo_head[EW-1:PC_W];
  assign out_pc        = fifo_head[PC_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized-ready checks of instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [3:0]  imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [21:0] imem_rsp_data;
  logic        out_valid;
  logic [21:0] out_instr;
  logic [3:0]  out_pc;
  logic        out_ready;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;

  int tests_run;
  int tests_failed;

  logic        pend_v;
  logic [3:0]  pend_a;
  logic        s_req_v, s_req_fire, s_out_v, s_out_fire;
  logic [3:0]  s_req_a, s_out_pc;
  logic [21:0] s_out_instr;

  instr_fetch_unit #(.DEPTH(4), .PC_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] instr_of(input logic [3:0] pc);
    return {6'h2D, pc, pc ^ 4'hF, 4'h3, pc};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at a negedge: drive inputs, sample outputs mid-cycle, return at the next negedge.
  task automatic tick(input logic rdy, input logic ordy, input logic redir, input logic [3:0] rpc);
    imem_req_ready = rdy;
    out_ready      = ordy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = pend_v;
    imem_rsp_data  = pend_v ? instr_of(pend_a) : 22'h3FFFFF;
    #2;
    s_req_v     = imem_req_valid;
    s_req_a     = imem_req_addr;
    s_req_fire  = imem_req_valid && imem_req_ready;
    s_out_v     = out_valid;
    s_out_pc    = out_pc;
    s_out_instr = out_instr;
    s_out_fire  = out_valid && out_ready;
    pend_v      = s_req_fire;
    pend_a      = imem_req_addr;
    @(negedge clk);
  endtask

  task automatic expect_req(input string tag, input logic v, input logic [3:0] addr);
    check_eq({tag, "_req_valid"}, 32'(s_req_v), 32'(v));
    if (v) check_eq({tag, "_req_addr"}, 32'(s_req_a), 32'(addr));
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [3:0] pc);
    check_eq({tag, "_out_valid"}, 32'(s_out_v), 32'(v));
    if (v) begin
      check_eq({tag, "_out_pc"}, 32'(s_out_pc), 32'(pc));
      check_eq({tag, "_out_instr"}, 32'(s_out_instr), 32'(instr_of(pc)));
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    pend_v         = 1'b0;
    pend_a         = '0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int issued;
    int delivered;
    logic [3:0] exp_pc;
    tests_run    = 0;
    tests_failed = 0;

    // Streaming from reset: one request and, two cycles later, one delivery per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 1'b0, 4'd0);
      expect_req("stream", 1'b1, 4'(i));
      expect_out("stream", i >= 2, 4'(i - 2));
    end

    // Back-pressure: four entries buffer, requests stop, head held stable.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b0, 4'd0);
      expect_req("bp", i < 4, 4'(i));
      expect_out("bp", i >= 2, 4'd0);
    end
    check_eq("bp_state_hold", 32'(dut.state_q), 32'd1);
    check_eq("bp_count", 32'(dut.fifo_count), 32'd4);
    for (int j = 0; j < 8; j++) begin
      tick(1'b1, 1'b1, 1'b0, 4'd0);
      expect_out("drain", 1'b1, 4'(j));
    end

    // Redirect to 9 with pc 2..4 queued and pc 5 in flight; head popped in the redirect cycle.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    expect_req("pre_redir", 1'b1, 4'd4);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    expect_req("pre_redir", 1'b1, 4'd5);
    tick(1'b1, 1'b1, 1'b1, 4'd9);
    expect_req("redir_cyc", 1'b0, 4'd0);
    expect_out("redir_cyc", 1'b1, 4'd2);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    expect_req("redir_st", 1'b0, 4'd0);
    expect_out("redir_st", 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    expect_req("redir_first", 1'b1, 4'd9);
    expect_out("redir_first", 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    expect_out("redir_gap", 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    expect_out("redir_out", 1'b1, 4'd9);

    // Redirect held two cycles: the last target wins.
    tick(1'b1, 1'b1, 1'b1, 4'd3);
    expect_req("multi_r0", 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b1, 4'd12);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    expect_req("multi_redir", 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    expect_req("multi_first", 1'b1, 4'd12);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    expect_out("multi_out", 1'b1, 4'd12);

    // Address wrap from 14.
    tick(1'b1, 1'b1, 1'b1, 4'd14);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b1, 1'b0, 4'd0);
      expect_req("wrap", 1'b1, 4'(14 + k));
      expect_out("wrap", k >= 2, 4'(12 + k));
    end

    // Random memory and decode readiness: delivered pcs contiguous, nothing lost.
    do_reset();
    issued    = 0;
    delivered = 0;
    exp_pc    = 4'd0;
    for (int i = 0; i < 300; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0, 4'd0);
      if (s_req_fire) issued++;
      if (s_out_fire) begin
        check_eq("rand_pc", 32'(s_out_pc), 32'(exp_pc));
        check_eq("rand_instr", 32'(s_out_instr), 32'(instr_of(exp_pc)));
        exp_pc = exp_pc + 4'd1;
        delivered++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b0, 4'd0);
      if (s_out_fire) begin
        check_eq("rand_drain_pc", 32'(s_out_pc), 32'(exp_pc));
        exp_pc = exp_pc + 4'd1;
        delivered++;
      end
    end
    check_eq("rand_no_loss", 32'(delivered), 32'(issued));
    check_eq("rand_progress", 32'(delivered > 50), 32'd1);

    // Reset with a full credit window, then a stray response right after release.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 4'd0);
    check_eq("mid_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    do_reset();
    pend_v = 1'b1;
    pend_a = 4'd7;
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    expect_req("post_rst", 1'b1, 4'd0);
    expect_out("post_rst", 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    expect_out("post_rst_stray", 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    expect_out("post_rst_first", 1'b1, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
